// File: rtl/vend_pkg.sv
// vend_pkg: shared checkout state, coin encodings and coin value decode.
package vend_pkg;
  typedef enum logic [1:0] {IDLE, PAY, DISPENSE, DONE} state_e;
  localparam logic [1:0] SEL_1  = 2'd0;
  localparam logic [1:0] SEL_5  = 2'd1;
  localparam logic [1:0] SEL_10 = 2'd2;
  localparam logic [1:0] SEL_20 = 2'd3;
  localparam int COIN_1  = 1;
  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;
  localparam int COIN_20 = 20;
  function automatic logic [4:0] coin_value(input logic [1:0] sel);
    return sel == SEL_20 ? 5'(COIN_20) : sel == SEL_10 ? 5'(COIN_10) :
           sel == SEL_5  ? 5'(COIN_5)  : 5'(COIN_1);
  endfunction
endpackage

// File: rtl/change_sel.sv
// change_sel: greedy picker of the largest change coin not exceeding remain.
module change_sel
  import vend_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] remain_i,
  output logic [1:0]   sel_o,
  output logic [W-1:0] value_o
);
  assign sel_o   = remain_i >= W'(COIN_10) ? SEL_10 : remain_i >= W'(COIN_5) ? SEL_5 : SEL_1;
  assign value_o = W'(coin_value(sel_o));
endmodule

// File: rtl/pay_change.sv
// pay_change: checkout stage collecting coins and paying change/refund coin by coin.
module pay_change
  import vend_pkg::*;
#(
  parameter int PRICE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PRICE_W-1:0] total_price,
  input  logic               coin_in_valid,
  input  logic [1:0]         coin_in_sel,
  input  logic               confirm,
  input  logic               cancel,
  input  logic               chg_ready,
  output logic [PRICE_W-1:0] paid,
  output logic               busy,
  output logic               coin_reject,
  output logic               insufficient,
  output logic               chg_valid,
  output logic [1:0]         chg_sel,
  output logic               done
);
  state_e state_q, state_d;
  logic [PRICE_W-1:0] paid_q, paid_d, due_q, due_d, remain_q, remain_d, chg_val;
  logic [1:0] pick_sel;
  logic [PRICE_W:0] sum;
  logic rej_q, rej_d, insuf_q, insuf_d;
  change_sel #(.W(PRICE_W)) u_sel (.remain_i(remain_q), .sel_o(pick_sel), .value_o(chg_val));
  assign sum = {1'b0, paid_q} + (PRICE_W+1)'(coin_value(coin_in_sel));
  always_comb begin
    state_d  = state_q;
    paid_d   = paid_q;
    due_d    = due_q;
    remain_d = remain_q;
    rej_d    = 1'b0;
    insuf_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        due_d   = total_price;
        paid_d  = '0;
        state_d = PAY;
      end
      PAY: if (cancel) begin
        remain_d = paid_q;
        state_d  = paid_q == '0 ? DONE : DISPENSE;
        rej_d    = coin_in_valid;
      end else if (confirm) begin
        rej_d    = coin_in_valid;
        insuf_d  = paid_q < due_q;
        remain_d = paid_q < due_q ? remain_q : paid_q - due_q;
        state_d  = paid_q < due_q ? PAY : paid_q == due_q ? DONE : DISPENSE;
      end else if (coin_in_valid) begin
        rej_d  = sum[PRICE_W];
        paid_d = sum[PRICE_W] ? paid_q : sum[PRICE_W-1:0];
      end
      DISPENSE: begin
        rej_d = coin_in_valid;
        if (chg_ready) begin
          remain_d = remain_q - chg_val;
          state_d  = remain_q == chg_val ? DONE : DISPENSE;
        end
      end
      DONE: begin
        rej_d   = coin_in_valid;
        paid_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      paid_q   <= '0;
      due_q    <= '0;
      remain_q <= '0;
      rej_q    <= 1'b0;
      insuf_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      paid_q   <= paid_d;
      due_q    <= due_d;
      remain_q <= remain_d;
      rej_q    <= rej_d;
      insuf_q  <= insuf_d;
    end
  end
  assign paid         = paid_q;
  assign busy         = state_q != IDLE;
  assign coin_reject  = rej_q;
  assign insufficient = insuf_q;
  assign chg_valid    = state_q == DISPENSE;
  assign chg_sel      = chg_valid ? pick_sel : 2'd0;
  assign done         = state_q == DONE;
endmodule

// File: tb/tb_pay_change.sv
// tb_pay_change: directed checkout scenarios with a change-coin scoreboard.
module tb_pay_change;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, coin_in_valid = 1'b0, confirm = 1'b0, cancel = 1'b0, chg_ready = 1'b0;
  logic [7:0] total_price = '0;
  logic [1:0] coin_in_sel = '0;
  logic [7:0] paid;
  logic busy, coin_reject, insufficient, chg_valid, done;
  logic [1:0] chg_sel;
  int tests = 0, fails = 0;
  int exp_q[$];

  pay_change #(.PRICE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .total_price(total_price),
    .coin_in_valid(coin_in_valid), .coin_in_sel(coin_in_sel), .confirm(confirm),
    .cancel(cancel), .chg_ready(chg_ready), .paid(paid), .busy(busy),
    .coin_reject(coin_reject), .insufficient(insufficient), .chg_valid(chg_valid),
    .chg_sel(chg_sel), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic begin_co(input logic [7:0] price);
    start = 1'b1;
    total_price = price;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("paid_after_start", paid, 0);
  endtask

  task automatic coin(input logic [1:0] sel);
    coin_in_valid = 1'b1;
    coin_in_sel = sel;
    step();
    coin_in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    chg_ready = 1'b1;
    while (exp_q.size() > 0 && n < budget) begin
      if (chg_valid) chk("chg_sel", chg_sel, exp_q.pop_front());
      step();
      n++;
    end
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("done_pulse", done, 1);
    chk("valid_low_in_done", chg_valid, 0);
    chg_ready = 1'b0;
    step();
    chk("done_cleared", done, 0);
    chk("idle_after_done", busy, 0);
    chk("paid_cleared", paid, 0);
    exp_q.delete();
  endtask

  initial begin
    step();
    chk("rst_busy", busy, 0);
    chk("rst_paid", paid, 0);
    chk("rst_valid", chg_valid, 0);
    chk("rst_sel", chg_sel, 0);
    chk("rst_done", done, 0);
    chk("rst_reject", coin_reject, 0);
    chk("rst_insuf", insufficient, 0);
    rst = 1'b1;
    step();

    // price 37, pay 40, change 1,1,1
    begin_co(8'd37);
    coin(2'd3); chk("paid_20", paid, 20);
    coin(2'd3); chk("paid_40", paid, 40);
    confirm = 1'b1; exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    step(); confirm = 1'b0;
    chk("valid_after_confirm", chg_valid, 1);
    drain(20);

    // price 23, insufficient then change 5,1,1
    begin_co(8'd23);
    coin(2'd2); chk("paid_10", paid, 10);
    confirm = 1'b1; step(); confirm = 1'b0;
    chk("insuf_pulse", insufficient, 1);
    chk("insuf_stays_pay", busy, 1);
    chk("insuf_no_valid", chg_valid, 0);
    chk("insuf_paid", paid, 10);
    step();
    chk("insuf_one_cycle", insufficient, 0);
    coin(2'd3); chk("paid_30", paid, 30);
    confirm = 1'b1; exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
    step(); confirm = 1'b0;
    drain(20);

    // cancel refund 26 -> 10,10,5,1
    begin_co(8'd50);
    coin(2'd3); coin(2'd1); coin(2'd0);
    chk("paid_26", paid, 26);
    cancel = 1'b1; exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
    step(); cancel = 1'b0;
    drain(20);

    // stall with chg_ready low; coin during dispense rejected
    begin_co(8'd5);
    coin(2'd3);
    confirm = 1'b1; step(); confirm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", chg_valid, 1);
      chk("stall_sel", chg_sel, 2);
      if (i == 1) chk("dispense_coin_reject", coin_reject, 1);
      coin_in_valid = (i == 0);
      coin_in_sel = 2'd0;
      step();
    end
    coin_in_valid = 1'b0;
    chk("dispense_paid_unchanged", paid, 20);
    exp_q.push_back(2); exp_q.push_back(1);
    drain(20);

    // overflow reject at 250, then coin with confirm, exact payment
    begin_co(8'd251);
    for (int i = 0; i < 12; i++) coin(2'd3);
    coin(2'd2);
    chk("paid_250", paid, 250);
    coin(2'd2);
    chk("overflow_reject", coin_reject, 1);
    chk("overflow_paid", paid, 250);
    coin(2'd0);
    chk("accept_reject_low", coin_reject, 0);
    chk("paid_251", paid, 251);
    coin_in_valid = 1'b1; coin_in_sel = 2'd0; confirm = 1'b1;
    step();
    coin_in_valid = 1'b0; confirm = 1'b0;
    chk("confirm_coin_reject", coin_reject, 1);
    chk("exact_done", done, 1);
    chk("exact_no_valid", chg_valid, 0);
    chk("exact_paid_held", paid, 251);
    step();
    chk("exact_idle", busy, 0);

    // price 40 paid exactly
    begin_co(8'd40);
    coin(2'd3); coin(2'd3);
    confirm = 1'b1; step(); confirm = 1'b0;
    chk("exact40_done", done, 1);
    chk("exact40_no_valid", chg_valid, 0);
    step();
    chk("exact40_idle", busy, 0);

    // async reset mid-dispense
    begin_co(8'd0);
    coin(2'd3);
    confirm = 1'b1; step(); confirm = 1'b0;
    chg_ready = 1'b1; step();
    chk("mid_valid", chg_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", chg_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_paid", paid, 0);
    chk("arst_done", done, 0);
    chg_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("post_rst_idle", busy, 0);
    chk("post_rst_valid", chg_valid, 0);
    begin_co(8'd5);
    coin(2'd1); chk("clean_paid", paid, 5);
    confirm = 1'b1; step(); confirm = 1'b0;
    chk("clean_done", done, 1);
    step();
    chk("clean_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
